// File: rtl/bsg_cover_pkg.sv
// Shared types and sizing helpers for the counted coverage collector.
package bsg_cover_pkg;

  // Collector phases: accept tags, emit the header beat, emit one beat per entry.
  typedef enum logic [1:0] {
    FILL  = 2'd0,
    HDR   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Index width that never collapses to zero bits for a single-element range.
  function automatic int safe_clog2(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Width needed to hold a population count of n bits (0..n inclusive).
  function automatic int occ_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/bsg_cover_counted_if.sv
// Producer and drain-side signals of the counted coverage collector.
// The slave modport is the collector; the master modport is the environment
// (tag producer plus the downstream daisy-chain arbiter).
interface bsg_cover_counted_if #(
  parameter int width_p     = 32,
  parameter int cnt_width_p = 8
);

  // Tag input side
  logic                   v_i;
  logic [width_p-1:0]     data_i;
  logic                   ready_o;
  logic                   drain_i;
  logic                   gate_o;
  logic                   overflow_o;

  // Drain output side
  logic                   v_o;
  logic                   ready_i;
  logic                   idx_v_o;
  logic [width_p-1:0]     data_o;
  logic [cnt_width_p-1:0] cnt_o;

  modport slave (
    input  v_i, data_i, drain_i, ready_i,
    output ready_o, gate_o, overflow_o, v_o, idx_v_o, data_o, cnt_o
  );

  modport master (
    output v_i, data_i, drain_i, ready_i,
    input  ready_o, gate_o, overflow_o, v_o, idx_v_o, data_o, cnt_o
  );

endinterface

// File: rtl/bsg_cover_entry_array.sv
// Tag / valid / hit-counter storage with associative match, lowest-free
// selection and an indexed snoop port for the drain mux.
module bsg_cover_entry_array
  import bsg_cover_pkg::*;
#(
  parameter  int width_p     = 32,
  parameter  int els_p       = 16,
  parameter  int cnt_width_p = 8,
  localparam int lg_els_lp   = safe_clog2(els_p)
) (
  input  logic                   clk_i,
  input  logic                   reset_i,

  // Associative lookup
  input  logic [width_p-1:0]     match_data_i,
  output logic [els_p-1:0]       match_oh_o,
  output logic [els_p-1:0]       free_oh_o,
  output logic                   free_v_o,
  output logic [els_p-1:0]       valid_o,

  // Update ports (one-hot, mutually exclusive per entry by construction)
  input  logic [els_p-1:0]       inc_oh_i,
  input  logic [els_p-1:0]       write_oh_i,
  input  logic [width_p-1:0]     write_data_i,
  input  logic [els_p-1:0]       invalidate_oh_i,
  input  logic [els_p-1:0]       zero_oh_i,

  // Snoop read
  input  logic [lg_els_lp-1:0]   rd_idx_i,
  output logic [width_p-1:0]     rd_tag_o,
  output logic [cnt_width_p-1:0] rd_cnt_o
);

  logic [width_p-1:0]     r_tag [els_p];
  logic [cnt_width_p-1:0] r_cnt [els_p];
  logic [els_p-1:0]       r_valid;

  logic [els_p-1:0]       w_free;

  // Tag storage: loaded only when an entry is allocated.
  // NOTE: tags carry no reset; an entry's tag is never observed while its valid bit is clear, so resetting them would only add reset fan-out.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < els_p; i++) begin
      if (write_oh_i[i]) r_tag[i] <= write_data_i;
    end
  end

  // Valid bits and saturating hit counters.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_valid <= '0;
      for (int i = 0; i < els_p; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < els_p; i++) begin
        if (write_oh_i[i]) begin
          r_valid[i] <= 1'b1;
          r_cnt[i]   <= cnt_width_p'(1);
        end else if (inc_oh_i[i]) begin
          if (r_cnt[i] != '1) r_cnt[i] <= r_cnt[i] + cnt_width_p'(1);
        end else if (invalidate_oh_i[i]) begin
          r_valid[i] <= 1'b0;
          r_cnt[i]   <= '0;
        end else if (zero_oh_i[i]) begin
          r_cnt[i]   <= '0;
        end
      end
    end
  end

  // Tags among valid entries are unique, so at most one entry matches.
  always_comb begin
    match_oh_o = '0;
    for (int i = 0; i < els_p; i++) begin
      match_oh_o[i] = r_valid[i] && (r_tag[i] == match_data_i);
    end
  end

  assign w_free = ~r_valid;

  bsg_priority_encode_one_hot_out #(
    .width_p (els_p)
  ) u_free_pe (
    .i   (w_free),
    .o   (free_oh_o),
    .v_o (free_v_o)
  );

  assign valid_o  = r_valid;
  assign rd_tag_o = r_tag[rd_idx_i];
  assign rd_cnt_o = r_cnt[rd_idx_i];

endmodule

// File: rtl/bsg_encode_one_hot.sv
// Converts a one-hot (or all-zero) vector into a binary index.
module bsg_encode_one_hot
  import bsg_cover_pkg::*;
#(
  parameter  int width_p     = 4,
  localparam int lg_width_lp = safe_clog2(width_p)
) (
  input  logic [width_p-1:0]     i,
  output logic [lg_width_lp-1:0] addr_o
);

  // OR together the indices of all set bits; exact for one-hot input.
  always_comb begin
    addr_o = '0;
    for (int k = 0; k < width_p; k++) begin
      if (i[k]) addr_o = addr_o | lg_width_lp'(k);
    end
  end

endmodule

// File: rtl/bsg_priority_encode_one_hot_out.sv
// Keeps only the lowest set bit of the input vector.
module bsg_priority_encode_one_hot_out #(
  parameter int width_p = 4
) (
  input  logic [width_p-1:0] i,
  output logic [width_p-1:0] o,
  output logic               v_o
);

  // Two's-complement trick: i & -i isolates the least significant one.
  assign o   = i & (~i + width_p'(1));
  assign v_o = |i;

endmodule

// File: rtl/bsg_cover_counted.sv
// Counted coverage collector: deduplicates tags into an associative array
// with per-tag hit counters, then drains a header beat and one beat per
// valid entry on request (or automatically when full in clear mode).
module bsg_cover_counted
  import bsg_cover_pkg::*;
#(
  parameter int idx_p            = 0,
  parameter int width_p          = 32,
  parameter int els_p            = 16,
  parameter int cnt_width_p      = 8,
  parameter int clear_on_drain_p = 1
) (
  input  logic                clk_i,
  input  logic                reset_i,
  bsg_cover_counted_if.slave  cov_if
);

  localparam int lg_els_lp    = safe_clog2(els_p);
  localparam int occ_width_lp = occ_width(els_p);
  localparam bit clear_lp     = (clear_on_drain_p != 0);

  state_e                 r_state;
  logic [els_p-1:0]       r_pending;
  logic                   r_overflow;
  logic                   r_ready;
  logic                   r_gate;
  logic                   r_idx_v;

  logic [els_p-1:0]       w_match_oh;
  logic [els_p-1:0]       w_free_oh;
  logic                   w_free_v;
  logic [els_p-1:0]       w_valid;
  logic                   w_accept;
  logic                   w_hit;
  logic                   w_drop;
  logic                   w_fills;
  logic                   w_go_hdr;
  logic [els_p-1:0]       w_inc_oh;
  logic [els_p-1:0]       w_write_oh;
  logic [els_p-1:0]       w_inval_oh;
  logic [els_p-1:0]       w_zero_oh;
  logic [els_p-1:0]       w_pend_oh;
  logic                   w_pend_v;
  logic [lg_els_lp-1:0]   w_pend_idx;
  logic [width_p-1:0]     w_rd_tag;
  logic [cnt_width_p-1:0] w_rd_cnt;
  logic [occ_width_lp-1:0] w_occ;
  logic                   w_out_v;
  logic                   w_drain_fire;

  // ---------------------------------------------------------------------
  // Accept path
  // ---------------------------------------------------------------------
  assign w_accept = (r_state == FILL) && cov_if.v_i;
  assign w_hit    = |w_match_oh;
  assign w_drop   = w_accept && !w_hit && !w_free_v;

  // Allocation fills the array when the chosen free slot is the only one left.
  assign w_fills  = (|w_write_oh) && (&(w_valid | w_free_oh));
  assign w_go_hdr = cov_if.drain_i || (clear_lp && w_fills);

  // Route the accepted tag to either a counter bump or a fresh allocation.
  // NOTE: every output of this block gets a default first so no path leaves one unassigned and infers a latch.
  always_comb begin
    w_inc_oh   = '0;
    w_write_oh = '0;
    if (w_accept) begin
      if (w_hit) w_inc_oh   = w_match_oh;
      else       w_write_oh = w_free_oh;
    end
  end

  // ---------------------------------------------------------------------
  // Drain path
  // ---------------------------------------------------------------------
  bsg_priority_encode_one_hot_out #(
    .width_p (els_p)
  ) u_pend_pe (
    .i   (r_pending),
    .o   (w_pend_oh),
    .v_o (w_pend_v)
  );

  bsg_encode_one_hot #(
    .width_p (els_p)
  ) u_pend_enc (
    .i      (w_pend_oh),
    .addr_o (w_pend_idx)
  );

  assign w_out_v      = r_idx_v || ((r_state == DRAIN) && w_pend_v);
  assign w_drain_fire = (r_state == DRAIN) && w_pend_v && cov_if.ready_i;

  // A drained entry is either released or keeps its tag with a cleared count.
  always_comb begin
    w_inval_oh = '0;
    w_zero_oh  = '0;
    if (w_drain_fire) begin
      if (clear_lp) w_inval_oh = w_pend_oh;
      else          w_zero_oh  = w_pend_oh;
    end
  end

  // Number of valid entries reported in the header beat.
  always_comb begin
    w_occ = '0;
    for (int k = 0; k < els_p; k++) begin
      w_occ = w_occ + occ_width_lp'(w_valid[k]);
    end
  end

  bsg_cover_entry_array #(
    .width_p     (width_p),
    .els_p       (els_p),
    .cnt_width_p (cnt_width_p)
  ) u_array (
    .clk_i           (clk_i),
    .reset_i         (reset_i),
    .match_data_i    (cov_if.data_i),
    .match_oh_o      (w_match_oh),
    .free_oh_o       (w_free_oh),
    .free_v_o        (w_free_v),
    .valid_o         (w_valid),
    .inc_oh_i        (w_inc_oh),
    .write_oh_i      (w_write_oh),
    .write_data_i    (cov_if.data_i),
    .invalidate_oh_i (w_inval_oh),
    .zero_oh_i       (w_zero_oh),
    .rd_idx_i        (w_pend_idx),
    .rd_tag_o        (w_rd_tag),
    .rd_cnt_o        (w_rd_cnt)
  );

  // ---------------------------------------------------------------------
  // Control FSM with registered status outputs
  // ---------------------------------------------------------------------
  // Sequences FILL -> HDR -> DRAIN -> FILL and tracks pending/overflow.
  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state    <= FILL;
      r_pending  <= '0;
      r_overflow <= 1'b0;
      r_ready    <= 1'b1;
      r_gate     <= 1'b0;
      r_idx_v    <= 1'b0;
    end else begin
      case (r_state)
        FILL: begin
          if (w_drop) r_overflow <= 1'b1;
          if (w_go_hdr) begin
            r_state <= HDR;
            r_ready <= 1'b0;
            r_gate  <= 1'b1;
            r_idx_v <= 1'b1;
          end
        end
        HDR: begin
          if (cov_if.ready_i) begin
            r_state    <= DRAIN;
            r_pending  <= w_valid;
            r_overflow <= 1'b0;
            r_idx_v    <= 1'b0;
          end
        end
        DRAIN: begin
          if (!w_pend_v || (cov_if.ready_i && (r_pending == w_pend_oh))) begin
            r_state <= FILL;
            r_ready <= 1'b1;
            r_gate  <= 1'b0;
          end
          if (w_drain_fire) r_pending <= r_pending & ~w_pend_oh;
        end
        default: begin
          r_state <= FILL;
          r_ready <= 1'b1;
          r_gate  <= 1'b0;
          r_idx_v <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign cov_if.ready_o    = r_ready;
  assign cov_if.gate_o     = r_gate;
  assign cov_if.overflow_o = r_overflow;
  assign cov_if.v_o        = w_out_v;
  assign cov_if.idx_v_o    = r_idx_v;
  assign cov_if.data_o     = r_idx_v ? width_p'(idx_p)         : w_rd_tag;
  assign cov_if.cnt_o      = r_idx_v ? cnt_width_p'(w_occ)     : w_rd_cnt;

endmodule

// File: tb/tb_bsg_cover_counted.sv
// Directed bench for bsg_cover_counted: one instance in clear-on-drain mode
// (idx 5, 4 entries, 4-bit counters) and one in retain mode (idx 3, 2 entries).
module tb_bsg_cover_counted;

  localparam logic [31:0] TAG_A = 32'hA000_0001;
  localparam logic [31:0] TAG_B = 32'hB000_0002;
  localparam logic [31:0] TAG_C = 32'hC000_0003;
  localparam logic [31:0] TAG_D = 32'hD000_0004;
  localparam logic [31:0] TAG_E = 32'hE000_0005;
  localparam logic [31:0] TAG_F = 32'hF000_0006;

  logic clk = 1'b0;
  logic a_reset;
  logic r_reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  bsg_cover_counted_if #(.width_p(32), .cnt_width_p(4)) a_if ();
  bsg_cover_counted_if #(.width_p(32), .cnt_width_p(8)) r_if ();

  bsg_cover_counted #(
    .idx_p(5), .width_p(32), .els_p(4), .cnt_width_p(4), .clear_on_drain_p(1)
  ) u_dut_a (
    .clk_i   (clk),
    .reset_i (a_reset),
    .cov_if  (a_if)
  );

  bsg_cover_counted #(
    .idx_p(3), .width_p(32), .els_p(2), .cnt_width_p(8), .clear_on_drain_p(0)
  ) u_dut_r (
    .clk_i   (clk),
    .reset_i (r_reset),
    .cov_if  (r_if)
  );

  // ---------------- stimulus helpers (no checking inside) ----------------
  task automatic a_send(input logic [31:0] tag);
    a_if.v_i = 1'b1; a_if.data_i = tag;
    @(negedge clk);
    a_if.v_i = 1'b0;
  endtask

  task automatic a_drain();
    a_if.drain_i = 1'b1;
    @(negedge clk);
    a_if.drain_i = 1'b0;
  endtask

  task automatic a_take(output logic ok, output logic hdr,
                        output logic [31:0] data, output logic [3:0] cnt);
    int n;
    ok = 1'b0; hdr = 1'b0; data = '0; cnt = '0; n = 0;
    while (a_if.v_o !== 1'b1 && n < 16) begin
      @(negedge clk); n++;
    end
    if (a_if.v_o === 1'b1) begin
      ok = 1'b1; hdr = a_if.idx_v_o; data = a_if.data_o; cnt = a_if.cnt_o;
      a_if.ready_i = 1'b1;
      @(negedge clk);
      a_if.ready_i = 1'b0;
    end
  endtask

  task automatic r_send(input logic [31:0] tag);
    r_if.v_i = 1'b1; r_if.data_i = tag;
    @(negedge clk);
    r_if.v_i = 1'b0;
  endtask

  task automatic r_drain();
    r_if.drain_i = 1'b1;
    @(negedge clk);
    r_if.drain_i = 1'b0;
  endtask

  task automatic r_take(output logic ok, output logic hdr,
                        output logic [31:0] data, output logic [7:0] cnt);
    int n;
    ok = 1'b0; hdr = 1'b0; data = '0; cnt = '0; n = 0;
    while (r_if.v_o !== 1'b1 && n < 16) begin
      @(negedge clk); n++;
    end
    if (r_if.v_o === 1'b1) begin
      ok = 1'b1; hdr = r_if.idx_v_o; data = r_if.data_o; cnt = r_if.cnt_o;
      r_if.ready_i = 1'b1;
      @(negedge clk);
      r_if.ready_i = 1'b0;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    a_reset = 1'b1; r_reset = 1'b1;
    repeat (3) @(negedge clk);
    a_reset = 1'b0; r_reset = 1'b0;
    n_checks++;
    if ({a_if.ready_o, a_if.gate_o, a_if.v_o, a_if.idx_v_o, a_if.overflow_o} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_a: got rdy/gate/v/idx/ovf=%b want 10000",
               {a_if.ready_o, a_if.gate_o, a_if.v_o, a_if.idx_v_o, a_if.overflow_o});
    end
    n_checks++;
    if ({r_if.ready_o, r_if.gate_o, r_if.v_o, r_if.idx_v_o, r_if.overflow_o} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_r: got rdy/gate/v/idx/ovf=%b want 10000",
               {r_if.ready_o, r_if.gate_o, r_if.v_o, r_if.idx_v_o, r_if.overflow_o});
    end
  endtask

  task automatic test_dedup();
    logic ok, hdr; logic [31:0] d; logic [3:0] c;
    a_send(TAG_A); a_send(TAG_A); a_send(TAG_B); a_send(TAG_A);
    a_drain();
    n_checks++;
    if ({a_if.gate_o, a_if.ready_o} !== 2'b10) begin
      n_fail++; $display("FAIL dedup_gate: got gate/rdy=%b want 10", {a_if.gate_o, a_if.ready_o});
    end
    a_take(ok, hdr, d, c);
    n_checks++;
    if ({ok, hdr, d, c} !== {1'b1, 1'b1, 32'd5, 4'd2}) begin
      n_fail++; $display("FAIL dedup_hdr: got ok=%b hdr=%b data=%h cnt=%0d want 1 1 5 2", ok, hdr, d, c);
    end
    a_take(ok, hdr, d, c);
    n_checks++;
    if ({ok, hdr, d, c} !== {1'b1, 1'b0, TAG_A, 4'd3}) begin
      n_fail++; $display("FAIL dedup_a: got ok=%b hdr=%b data=%h cnt=%0d want 1 0 %h 3", ok, hdr, d, c, TAG_A);
    end
    a_take(ok, hdr, d, c);
    n_checks++;
    if ({ok, hdr, d, c} !== {1'b1, 1'b0, TAG_B, 4'd1}) begin
      n_fail++; $display("FAIL dedup_b: got ok=%b hdr=%b data=%h cnt=%0d want 1 0 %h 1", ok, hdr, d, c, TAG_B);
    end
    n_checks++;
    if ({a_if.ready_o, a_if.gate_o, a_if.v_o} !== 3'b100) begin
      n_fail++; $display("FAIL dedup_end: got rdy/gate/v=%b want 100", {a_if.ready_o, a_if.gate_o, a_if.v_o});
    end
  endtask

  task automatic test_auto_drain();
    logic ok, hdr; logic [31:0] d; logic [3:0] c;
    logic [31:0] tags [4];
    tags[0] = TAG_C; tags[1] = TAG_D; tags[2] = TAG_E; tags[3] = TAG_F;
    a_send(tags[0]); a_send(tags[1]); a_send(tags[2]);
    n_checks++;
    if (a_if.gate_o !== 1'b0) begin
      n_fail++; $display("FAIL auto_not_yet: got gate=%b want 0", a_if.gate_o);
    end
    a_send(tags[3]);
    n_checks++;
    if ({a_if.gate_o, a_if.ready_o} !== 2'b10) begin
      n_fail++; $display("FAIL auto_gate: got gate/rdy=%b want 10", {a_if.gate_o, a_if.ready_o});
    end
    a_take(ok, hdr, d, c);
    n_checks++;
    if ({ok, hdr, d, c} !== {1'b1, 1'b1, 32'd5, 4'd4}) begin
      n_fail++; $display("FAIL auto_hdr: got ok=%b hdr=%b data=%h cnt=%0d want 1 1 5 4", ok, hdr, d, c);
    end
    for (int i = 0; i < 4; i++) begin
      a_take(ok, hdr, d, c);
      n_checks++;
      if ({ok, hdr, d, c} !== {1'b1, 1'b0, tags[i], 4'd1}) begin
        n_fail++; $display("FAIL auto_beat%0d: got ok=%b hdr=%b data=%h cnt=%0d want 1 0 %h 1", i, ok, hdr, d, c, tags[i]);
      end
    end
  endtask

  task automatic test_empty_drain();
    logic ok, hdr; logic [31:0] d; logic [3:0] c;
    a_drain();
    a_take(ok, hdr, d, c);
    n_checks++;
    if ({ok, hdr, d, c} !== {1'b1, 1'b1, 32'd5, 4'd0}) begin
      n_fail++; $display("FAIL empty_hdr: got ok=%b hdr=%b data=%h cnt=%0d want 1 1 5 0", ok, hdr, d, c);
    end
    n_checks++;
    if ({a_if.v_o, a_if.gate_o, a_if.ready_o} !== 3'b010) begin
      n_fail++; $display("FAIL empty_drain_cycle: got v/gate/rdy=%b want 010", {a_if.v_o, a_if.gate_o, a_if.ready_o});
    end
    @(negedge clk);
    n_checks++;
    if ({a_if.v_o, a_if.gate_o, a_if.ready_o} !== 3'b001) begin
      n_fail++; $display("FAIL empty_back_fill: got v/gate/rdy=%b want 001", {a_if.v_o, a_if.gate_o, a_if.ready_o});
    end
  endtask

  task automatic test_saturation();
    logic ok, hdr; logic [31:0] d; logic [3:0] c;
    for (int i = 0; i < 20; i++) a_send(TAG_A);
    a_drain();
    a_take(ok, hdr, d, c);
    n_checks++;
    if ({ok, hdr, d, c} !== {1'b1, 1'b1, 32'd5, 4'd1}) begin
      n_fail++; $display("FAIL sat_hdr: got ok=%b hdr=%b data=%h cnt=%0d want 1 1 5 1", ok, hdr, d, c);
    end
    a_take(ok, hdr, d, c);
    n_checks++;
    if ({ok, hdr, d, c} !== {1'b1, 1'b0, TAG_A, 4'd15}) begin
      n_fail++; $display("FAIL sat_a: got ok=%b hdr=%b data=%h cnt=%0d want 1 0 %h 15", ok, hdr, d, c, TAG_A);
    end
  endtask

  task automatic test_back_to_back();
    logic ok, hdr; logic [31:0] d; logic [3:0] c;
    a_send(TAG_A); a_send(TAG_B); a_send(TAG_A);
    a_drain();
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if ({a_if.v_o, a_if.idx_v_o, a_if.data_o, a_if.cnt_o} !== {1'b1, 1'b1, 32'd5, 4'd2}) begin
        n_fail++; $display("FAIL bp_hdr_hold%0d: got v=%b idx=%b data=%h cnt=%0d want 1 1 5 2",
                           i, a_if.v_o, a_if.idx_v_o, a_if.data_o, a_if.cnt_o);
      end
      @(negedge clk);
    end
    a_take(ok, hdr, d, c);
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if ({a_if.v_o, a_if.idx_v_o, a_if.data_o, a_if.cnt_o} !== {1'b1, 1'b0, TAG_A, 4'd2}) begin
        n_fail++; $display("FAIL bp_beat_hold%0d: got v=%b idx=%b data=%h cnt=%0d want 1 0 %h 2",
                           i, a_if.v_o, a_if.idx_v_o, a_if.data_o, a_if.cnt_o, TAG_A);
      end
      @(negedge clk);
    end
    a_take(ok, hdr, d, c);
    n_checks++;
    if ({ok, hdr, d, c} !== {1'b1, 1'b0, TAG_A, 4'd2}) begin
      n_fail++; $display("FAIL bp_a: got ok=%b hdr=%b data=%h cnt=%0d want 1 0 %h 2", ok, hdr, d, c, TAG_A);
    end
    a_take(ok, hdr, d, c);
    n_checks++;
    if ({ok, hdr, d, c} !== {1'b1, 1'b0, TAG_B, 4'd1}) begin
      n_fail++; $display("FAIL bp_b: got ok=%b hdr=%b data=%h cnt=%0d want 1 0 %h 1", ok, hdr, d, c, TAG_B);
    end
    n_checks++;
    if ({a_if.v_o, a_if.ready_o} !== 2'b01) begin
      n_fail++; $display("FAIL bp_end: got v/rdy=%b want 01", {a_if.v_o, a_if.ready_o});
    end
  endtask

  task automatic test_reset_mid_drain();
    logic ok, hdr; logic [31:0] d; logic [3:0] c;
    a_send(TAG_A); a_send(TAG_B);
    a_drain();
    a_take(ok, hdr, d, c);
    n_checks++;
    if ({a_if.v_o, a_if.idx_v_o, a_if.data_o, a_if.cnt_o} !== {1'b1, 1'b0, TAG_A, 4'd1}) begin
      n_fail++; $display("FAIL mid_first_beat: got v=%b idx=%b data=%h cnt=%0d want 1 0 %h 1",
                         a_if.v_o, a_if.idx_v_o, a_if.data_o, a_if.cnt_o, TAG_A);
    end
    a_reset = 1'b1;
    @(negedge clk);
    a_reset = 1'b0;
    n_checks++;
    if ({a_if.ready_o, a_if.gate_o, a_if.v_o, a_if.idx_v_o} !== 4'b1000) begin
      n_fail++; $display("FAIL mid_reset: got rdy/gate/v/idx=%b want 1000",
                         {a_if.ready_o, a_if.gate_o, a_if.v_o, a_if.idx_v_o});
    end
    a_drain();
    a_take(ok, hdr, d, c);
    n_checks++;
    if ({ok, hdr, d, c} !== {1'b1, 1'b1, 32'd5, 4'd0}) begin
      n_fail++; $display("FAIL mid_wiped: got ok=%b hdr=%b data=%h cnt=%0d want 1 1 5 0", ok, hdr, d, c);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_retain_overflow();
    logic ok, hdr; logic [31:0] d; logic [7:0] c;
    r_send(TAG_A); r_send(TAG_B);
    n_checks++;
    if ({r_if.gate_o, r_if.ready_o, r_if.overflow_o} !== 3'b010) begin
      n_fail++; $display("FAIL ret_full_no_auto: got gate/rdy/ovf=%b want 010", {r_if.gate_o, r_if.ready_o, r_if.overflow_o});
    end
    r_send(TAG_C);
    n_checks++;
    if ({r_if.gate_o, r_if.ready_o, r_if.overflow_o} !== 3'b011) begin
      n_fail++; $display("FAIL ret_overflow: got gate/rdy/ovf=%b want 011", {r_if.gate_o, r_if.ready_o, r_if.overflow_o});
    end
    r_drain();
    r_take(ok, hdr, d, c);
    n_checks++;
    if ({ok, hdr, d, c} !== {1'b1, 1'b1, 32'd3, 8'd2}) begin
      n_fail++; $display("FAIL ret_hdr1: got ok=%b hdr=%b data=%h cnt=%0d want 1 1 3 2", ok, hdr, d, c);
    end
    n_checks++;
    if (r_if.overflow_o !== 1'b0) begin
      n_fail++; $display("FAIL ret_ovf_clear: got ovf=%b want 0", r_if.overflow_o);
    end
    r_take(ok, hdr, d, c);
    n_checks++;
    if ({ok, hdr, d, c} !== {1'b1, 1'b0, TAG_A, 8'd1}) begin
      n_fail++; $display("FAIL ret_a1: got ok=%b hdr=%b data=%h cnt=%0d want 1 0 %h 1", ok, hdr, d, c, TAG_A);
    end
    r_take(ok, hdr, d, c);
    n_checks++;
    if ({ok, hdr, d, c} !== {1'b1, 1'b0, TAG_B, 8'd1}) begin
      n_fail++; $display("FAIL ret_b1: got ok=%b hdr=%b data=%h cnt=%0d want 1 0 %h 1", ok, hdr, d, c, TAG_B);
    end
    n_checks++;
    if ({r_if.ready_o, r_if.v_o} !== 2'b10) begin
      n_fail++; $display("FAIL ret_fill: got rdy/v=%b want 10", {r_if.ready_o, r_if.v_o});
    end
    r_send(TAG_A);
    r_drain();
    r_take(ok, hdr, d, c);
    n_checks++;
    if ({ok, hdr, d, c} !== {1'b1, 1'b1, 32'd3, 8'd2}) begin
      n_fail++; $display("FAIL ret_hdr2: got ok=%b hdr=%b data=%h cnt=%0d want 1 1 3 2", ok, hdr, d, c);
    end
    r_take(ok, hdr, d, c);
    n_checks++;
    if ({ok, hdr, d, c} !== {1'b1, 1'b0, TAG_A, 8'd1}) begin
      n_fail++; $display("FAIL ret_a2: got ok=%b hdr=%b data=%h cnt=%0d want 1 0 %h 1", ok, hdr, d, c, TAG_A);
    end
    r_take(ok, hdr, d, c);
    n_checks++;
    if ({ok, hdr, d, c} !== {1'b1, 1'b0, TAG_B, 8'd0}) begin
      n_fail++; $display("FAIL ret_b2: got ok=%b hdr=%b data=%h cnt=%0d want 1 0 %h 0", ok, hdr, d, c, TAG_B);
    end
    n_checks++;
    if ({r_if.ready_o, r_if.v_o, r_if.gate_o} !== 3'b100) begin
      n_fail++; $display("FAIL ret_end: got rdy/v/gate=%b want 100", {r_if.ready_o, r_if.v_o, r_if.gate_o});
    end
  endtask

  // Hard stop in case a scenario wedges outside its bounded waits.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    a_reset = 1'b1; r_reset = 1'b1;
    a_if.v_i = 1'b0; a_if.data_i = '0; a_if.drain_i = 1'b0; a_if.ready_i = 1'b0;
    r_if.v_i = 1'b0; r_if.data_i = '0; r_if.drain_i = 1'b0; r_if.ready_i = 1'b0;
    @(negedge clk);
    test_reset();
    test_dedup();
    test_auto_drain();
    test_empty_drain();
    test_saturation();
    test_back_to_back();
    test_reset_mid_drain();
    test_retain_overflow();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
